bw_io_impctl_codegen: RTL and testbench
=======================================

// Module: bw_io_impctl_codegen
// PURPOSE
//  Upstream impedance-code generator for the IO impedance-control snap/shadow stage.
//  Filters the pad-vs-reference comparator result over fixed sample windows.
//  Steps an 8-bit impedance code up or down by one per window, with saturation and a dead band.
//  Drives z[7:0]; the downstream stage captures z on snap_enable and returns freeze.
// PARAMETERS
//  WIDTH      8     code width (z)
//  WIN_LOG2   4     log2 of samples per vote window (16)
//  THRESH     12    votes in one direction needed to step; 2^(WIN_LOG2-1) < THRESH <= 2^WIN_LOG2
//  SETTLE_CYC 8     clk cycles after a step during which comp_valid is ignored; >= 1
//  LOCK_REV   3     direction reversals needed to declare lock
//  INIT_CODE  8'h80 code value at reset
// PORTS
//  clk        in  1      core clock; all state on rising edge
//  reset      in  1      asynchronous, active-high; clears all state
//  enable     in  1      calibration enable; 0 = hold code, clear lock
//  freeze     in  1      from downstream stage; 1 = hold code, keep lock
//  comp_valid in  1      comparator sample strobe, one sample per cycle high
//  comp_hi    in  1      1 = pad impedance above reference (code must rise); sampled only with comp_valid
//  z          out WIDTH  current impedance code
//  locked     out 1      code is dithering about target
//  sat_hi     out 1      z == all-ones
//  sat_lo     out 1      z == 0
// BEHAVIOUR
//  Reset: z=INIT_CODE; locked=0; sat_hi/sat_lo decoded from z; state IDLE; all counters 0.
//  State IDLE: counters held at 0. Exits to ACCUM when enable=1 and freeze=0.
//  State ACCUM, per comp_valid=1 cycle:
//   - samp_cnt increments.
//   - hi_cnt (WIN_LOG2+1 bits) increments if comp_hi=1.
//   - The cycle that accepts sample 2^WIN_LOG2 moves to UPDATE.
//  State UPDATE (exactly 1 cycle); let N = 2^WIN_LOG2:
//   - Step up if hi_cnt >= THRESH: z+1, saturating at all-ones.
//   - Else step down if N-hi_cnt >= THRESH: z-1, saturating at 0.
//   - Else dead band: z unchanged.
//   - z is registered at the edge leaving UPDATE (one cycle after the last sample edge).
//   - Counters clear at the same edge. Next state SETTLE.
//  Lock tracking, evaluated in UPDATE:
//   - Keep last_dir (none/up/down) and rev_cnt (saturating).
//   - A step opposite to last_dir increments rev_cnt.
//   - A dead-band window sets locked=1 immediately.
//   - locked=1 when rev_cnt reaches LOCK_REV.
//   - Two consecutive same-direction steps clear rev_cnt and locked.
//   - A saturated step (z already at limit) counts as a same-direction step.
//  State SETTLE: count SETTLE_CYC cycles, comp_valid ignored, then ACCUM with a fresh window.
//  Freeze/enable (priority: reset > enable=0 > freeze > normal):
//   - Either condition moves any state to IDLE on the next edge and discards the partial window.
//   - In UPDATE with freeze=1 or enable=0 that cycle, the step is NOT committed.
//   - enable=0 also clears locked, rev_cnt and last_dir; freeze keeps them.
//   - On release, a full new window is collected before any step.
//  z changes only at the UPDATE exit edge or reset; z never wraps.
//  sat_hi and sat_lo are registered together with z.
// TESTING
//  1 Reset: assert reset mid-ACCUM -> z=0x80, locked=0, sat_hi=0, sat_lo=0, samp_cnt=0 immediately (async).
//  2 Up step: enable, 16 comp_valid with comp_hi=1 -> z=0x81 one cycle after UPDATE.
//    comp_valid pulses during the next 8 cycles are not counted.
//  3 Dead band: 16 samples with 8 high -> z unchanged at 0x80; locked=1.
//  4 Saturation: INIT_CODE=0xFE, three all-high windows -> z=0xFF then held.
//    sat_hi=1; no wrap to 0x00.
//  5 Freeze mid-window: 10 high samples, freeze=1 for 5 cycles, release, 16 low samples.
//    z=0x7F; the partial window is discarded. Freeze asserted exactly in UPDATE -> no step.
//  6 Lock by reversal: alternate all-high/all-low windows from 0x80.
//    locked=1 after the 3rd reversal. Then two all-high windows -> locked=0.
//    Then enable=0 -> locked=0 and z held.

Source files
------------

// File: rtl/bw_io_impctl_codegen.sv
`default_nettype none
// ============================================================================
// Module      : bw_io_impctl_codegen
// Description : Impedance code generator. Votes the comparator over fixed
//               sample windows and steps an 8-bit code with dead band and lock.
// Revision    : 1.0
// ============================================================================
module bw_io_impctl_codegen #(
    parameter int               WIDTH      = 8,
    parameter int               WIN_LOG2   = 4,
    parameter int               THRESH     = 12,
    parameter int               SETTLE_CYC = 8,
    parameter int               LOCK_REV   = 3,
    parameter logic [WIDTH-1:0] INIT_CODE  = 8'h80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    input  logic             comp_valid,
    input  logic             comp_hi,
    output logic [WIDTH-1:0] z,
    output logic             locked,
    output logic             sat_hi,
    output logic             sat_lo
);

    localparam int c_CW = WIN_LOG2 + 1;
    localparam int c_SW = $clog2(SETTLE_CYC + 1);
    localparam int c_RW = $clog2(LOCK_REV + 1);

    localparam logic [c_CW-1:0]  c_N_CNT    = c_CW'(1 << WIN_LOG2);
    localparam logic [c_CW-1:0]  c_LAST     = c_CW'((1 << WIN_LOG2) - 1);
    localparam logic [c_CW-1:0]  c_THR      = c_CW'(THRESH);
    localparam logic [c_SW-1:0]  c_SET_LAST = c_SW'(SETTLE_CYC - 1);
    localparam logic [c_RW-1:0]  c_REV_MAX  = c_RW'(LOCK_REV);
    localparam logic [WIDTH-1:0] c_ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ONES     = {WIDTH{1'b1}};

    localparam logic [1:0] c_DIR_NONE = 2'd0;
    localparam logic [1:0] c_DIR_UP   = 2'd1;
    localparam logic [1:0] c_DIR_DN   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [c_CW-1:0]  r_samp_cnt;
    logic [c_CW-1:0]  r_hi_cnt;
    logic [c_CW-1:0]  w_lo_cnt;
    logic [c_SW-1:0]  r_settle_cnt;
    logic [c_RW-1:0]  r_rev_cnt;
    logic [c_RW-1:0]  w_rev_inc;
    logic [1:0]       r_last_dir;
    logic [1:0]       w_dir;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] w_z_next;
    logic             r_locked;
    logic             r_sat_hi;
    logic             r_sat_lo;
    logic             w_hold;
    logic             w_commit;
    logic             w_up;
    logic             w_dn;

    assign z      = r_z;
    assign locked = r_locked;
    assign sat_hi = r_sat_hi;
    assign sat_lo = r_sat_lo;

    assign w_hold   = !enable || freeze;
    assign w_commit = (r_state == S_UPDATE) && !w_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_hold) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_next = S_ACCUM;
                S_ACCUM:  if (comp_valid && (r_samp_cnt == c_LAST)) w_next = S_UPDATE;
                S_UPDATE: w_next = S_SETTLE;
                S_SETTLE: if (r_settle_cnt == c_SET_LAST) w_next = S_ACCUM;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Counters only live inside their own state; any exit or hold clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_samp_cnt   <= '0;
            r_hi_cnt     <= '0;
            r_settle_cnt <= '0;
        end else begin
            if ((r_state == S_ACCUM) && !w_hold) begin
                if (comp_valid) begin
                    r_samp_cnt <= r_samp_cnt + 1'b1;
                    r_hi_cnt   <= r_hi_cnt + c_CW'(comp_hi);
                end
            end else if (r_state != S_UPDATE || w_hold || w_commit) begin
                r_samp_cnt <= '0;
                r_hi_cnt   <= '0;
            end
            if ((r_state == S_SETTLE) && !w_hold) begin
                r_settle_cnt <= r_settle_cnt + 1'b1;
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_lo_cnt  = c_N_CNT - r_hi_cnt;
        w_up      = (r_hi_cnt >= c_THR);
        w_dn      = !w_up && (w_lo_cnt >= c_THR);
        w_dir     = w_up ? c_DIR_UP : (w_dn ? c_DIR_DN : c_DIR_NONE);
        w_rev_inc = (r_rev_cnt >= c_REV_MAX) ? r_rev_cnt : r_rev_cnt + 1'b1;
        w_z_next  = r_z;
        if (w_up && (r_z != c_ONES)) begin
            w_z_next = r_z + c_ONE;
        end else if (w_dn && (r_z != '0)) begin
            w_z_next = r_z - c_ONE;
        end
    end

    // A saturated step still records its direction, so it counts toward unlock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_z        <= INIT_CODE;
            r_sat_hi   <= (INIT_CODE == c_ONES);
            r_sat_lo   <= (INIT_CODE == '0);
            r_locked   <= 1'b0;
            r_last_dir <= c_DIR_NONE;
            r_rev_cnt  <= '0;
        end else if (!enable) begin
            r_locked   <= 1'b0;
            r_last_dir <= c_DIR_NONE;
            r_rev_cnt  <= '0;
        end else if (w_commit) begin
            r_z      <= w_z_next;
            r_sat_hi <= (w_z_next == c_ONES);
            r_sat_lo <= (w_z_next == '0);
            if (w_dir == c_DIR_NONE) begin
                r_locked <= 1'b1;
            end else begin
                if (r_last_dir == w_dir) begin
                    r_rev_cnt <= '0;
                    r_locked  <= 1'b0;
                end else if (r_last_dir != c_DIR_NONE) begin
                    r_rev_cnt <= w_rev_inc;
                    if (w_rev_inc >= c_REV_MAX) begin
                        r_locked <= 1'b1;
                    end
                end
                r_last_dir <= w_dir;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bw_io_impctl_codegen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bw_io_impctl_codegen
// Description : Self-checking bench for bw_io_impctl_codegen with a window-vote
//               reference model, directed scenarios and random stimulus.
// Revision    : 1.0
// ============================================================================
module tb_bw_io_impctl_codegen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       freeze;
    logic       comp_valid;
    logic       comp_hi;
    logic [7:0] z;
    logic       locked;
    logic       sat_hi;
    logic       sat_lo;

    int n_vec = 0;
    int n_err = 0;
    bit run_chk = 1'b0;

    // Reference model: samples gathered in the current window, votes, settle gap.
    int m_z, m_locked, m_last, m_rev, m_samp, m_his, m_settle;
    bit m_active, m_upd;

    always #5 clk = ~clk;

    bw_io_impctl_codegen dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .freeze     (freeze),
        .comp_valid (comp_valid),
        .comp_hi    (comp_hi),
        .z          (z),
        .locked     (locked),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo)
    );

    task automatic m_drop_window();
        m_active = 1'b0;
        m_upd    = 1'b0;
        m_samp   = 0;
        m_his    = 0;
        m_settle = 0;
    endtask

    task automatic m_vote();
        int dir;
        if (m_his >= 12) begin
            dir = 1;
            if (m_z < 255) m_z = m_z + 1;
        end else if (16 - m_his >= 12) begin
            dir = -1;
            if (m_z > 0) m_z = m_z - 1;
        end else begin
            dir = 0;
        end
        if (dir == 0) begin
            m_locked = 1;
        end else begin
            if (m_last == dir) begin
                m_rev    = 0;
                m_locked = 0;
            end else if (m_last != 0) begin
                if (m_rev < 3) m_rev = m_rev + 1;
                if (m_rev == 3) m_locked = 1;
            end
            m_last = dir;
        end
        m_upd    = 1'b0;
        m_samp   = 0;
        m_his    = 0;
        m_settle = 8;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_z = 8'h80; m_locked = 0; m_last = 0; m_rev = 0;
            m_drop_window();
        end else if (!enable) begin
            m_drop_window();
            m_locked = 0; m_last = 0; m_rev = 0;
        end else if (freeze) begin
            m_drop_window();
        end else if (m_upd) begin
            m_vote();
        end else if (!m_active) begin
            m_active = 1'b1;
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
        end else if (comp_valid) begin
            m_samp = m_samp + 1;
            m_his  = m_his + int'(comp_hi);
            if (m_samp == 16) m_upd = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run_chk && !reset) begin
            chk("z",      32'(z),      32'(m_z));
            chk("locked", 32'(locked), 32'(m_locked));
            chk("sat_hi", 32'(sat_hi), 32'(m_z == 255));
            chk("sat_lo", 32'(sat_lo), 32'(m_z == 0));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; enable = 1'b0; freeze = 1'b0; comp_valid = 1'b0; comp_hi = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // 16 samples (first nhi high), then the update and settle cycles carry junk pulses.
    task automatic window(input int nhi);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            comp_valid = 1'b1;
            comp_hi    = (i < nhi);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            comp_valid = 1'b1;
            comp_hi    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        comp_valid = 1'b0;
    endtask

    initial begin
        int p_hi;
        reset = 1'b1; enable = 1'b0; freeze = 1'b0; comp_valid = 1'b0; comp_hi = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        run_chk = 1'b1;
        chk("rst_z", 32'(z), 32'h80);
        chk("rst_locked", 32'(locked), 32'h0);
        chk("rst_sat", 32'({sat_hi, sat_lo}), 32'h0);

        // Async reset in the middle of a window, then a full fresh window.
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            comp_valid = 1'b1; comp_hi = 1'b1;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_rst_z", 32'(z), 32'h80);
        chk("async_rst_locked", 32'(locked), 32'h0);
        chk("async_rst_sat", 32'({sat_hi, sat_lo}), 32'h0);
        @(negedge clk);
        reset = 1'b0; comp_valid = 1'b0;
        window(16);
        chk("up_step_z", 32'(z), 32'h81);
        window(0);
        chk("down_after_settle_z", 32'(z), 32'h80);

        // Dead band.
        do_reset();
        enable = 1'b1;
        window(8);
        chk("deadband_z", 32'(z), 32'h80);
        chk("deadband_locked", 32'(locked), 32'h1);

        // Freeze mid-window discards the partial window.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            comp_valid = 1'b1; comp_hi = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            freeze = 1'b1;
        end
        @(negedge clk);
        freeze = 1'b0; comp_valid = 1'b0;
        window(0);
        chk("freeze_window_z", 32'(z), 32'h7F);
        // Freeze exactly in the update cycle: no step.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            comp_valid = 1'b1; comp_hi = 1'b1;
        end
        @(negedge clk);
        freeze = 1'b1; comp_valid = 1'b0;
        @(negedge clk);
        freeze = 1'b0;
        @(negedge clk);
        chk("freeze_update_z", 32'(z), 32'h7F);

        // Lock by reversals, unlock by two same-direction steps, enable drop.
        do_reset();
        enable = 1'b1;
        window(16); window(0); window(16);
        chk("rev2_locked", 32'(locked), 32'h0);
        window(0);
        chk("rev3_locked", 32'(locked), 32'h1);
        chk("rev3_z", 32'(z), 32'h80);
        window(16);
        chk("rev_sat_locked", 32'(locked), 32'h1);
        window(16);
        chk("same_dir_unlock", 32'(locked), 32'h0);
        chk("same_dir_z", 32'(z), 32'h82);
        window(8);
        chk("relock_deadband", 32'(locked), 32'h1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("disable_locked", 32'(locked), 32'h0);
        chk("disable_z", 32'(z), 32'h82);

        // Saturation at both ends.
        do_reset();
        enable = 1'b1;
        repeat (129) window(16);
        chk("sat_hi_z", 32'(z), 32'hFF);
        chk("sat_hi_flag", 32'(sat_hi), 32'h1);
        repeat (257) window(0);
        chk("sat_lo_z", 32'(z), 32'h00);
        chk("sat_lo_flag", 32'(sat_lo), 32'h1);

        // Random traffic with occasional freeze/disable.
        do_reset();
        p_hi = 50;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (c % 40 == 0) p_hi = 25 * $urandom_range(0, 4);
            enable     = ($urandom_range(0, 79) != 0);
            freeze     = ($urandom_range(0, 79) == 0);
            comp_valid = ($urandom_range(0, 3) != 0);
            comp_hi    = ($urandom_range(0, 99) < p_hi);
        end
        @(negedge clk);
        run_chk = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
